// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of a 5-stage RISC-V pipeline.
//
// Owns the program counter, drives the combinational instruction memory
// address directly from it, and captures the returned word into the IF/ID
// pipeline register. Handles stalls, flushes, EX redirects, halt requests
// and a sticky fetch fault (misaligned or out-of-range PC).
//
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch/stall counters.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   stall_i         hold PC and IF/ID
//   flush_i         squash IF/ID
//   redirect_i      taken branch/jump from EX, target on redirect_pc_i
//   halt_i          stop fetching
//   imem_addr_o     byte address to imem (the PC register itself)
//   imem_instr_i    combinational imem read data
//   ifid_pc_o       PC of the instruction held in IF/ID
//   ifid_pc4_o      ifid_pc_o + 4
//   ifid_instr_o    instruction held in IF/ID
//   ifid_valid_o    IF/ID holds a real instruction
//   fault_o         sticky fetch fault
//   state_o         BOOT=00, RUN=01, HALT=10
//   fetch_count_o   (FETCH_PERF_CNT_EN) valid IF/ID loads
//   stall_count_o   (FETCH_PERF_CNT_EN) stalled RUN edges
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        fault_o,
    output logic [1:0]  state_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

    state_t      state_q, state_d;
    logic [31:0] pc_p0, pc_d;
    logic [31:0] ifid_pc_p1, ifid_pc4_p1, ifid_instr_p1;
    logic        vld_p1;
    logic        fault_q, fault_d;
    logic        capture, squash;
    logic [31:0] pc_plus4;
    logic        addr_fault;

    assign pc_plus4   = pc_p0 + 32'd4;
    // Any PC+4 wrap lands beyond PC_LIMIT first, so the range check covers it.
    assign addr_fault = (pc_p0[1:0] != 2'b00) || (pc_p0 >= PC_LIMIT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic        stall_inc;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_p0;
        fault_d = fault_q;
        capture = 1'b0;
        squash  = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        stall_inc = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt_i) begin
                    state_d = HALT;
                    squash  = 1'b1;
                end else if (addr_fault) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                    squash  = 1'b1;
                end else if (redirect_i) begin
                    // Redirect wins over stall: the stalled instruction is
                    // on the wrong path anyway.
                    pc_d   = redirect_pc_i;
                    squash = 1'b1;
                end else if (stall_i) begin
                    squash = flush_i;
`ifdef FETCH_PERF_CNT_EN
                    stall_inc = 1'b1;
`endif
                end else begin
                    pc_d    = pc_plus4;
                    squash  = flush_i;
                    capture = !flush_i;
                end
            end
            default: begin
                squash = 1'b1;
            end
        endcase
    end

    // Stage 0 -> 1: PC register and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_p0         <= RESET_PC;
            fault_q       <= 1'b0;
            ifid_pc_p1    <= 32'd0;
            ifid_pc4_p1   <= 32'd0;
            ifid_instr_p1 <= NOP_INSTR;
            vld_p1        <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_p0   <= pc_d;
            fault_q <= fault_d;
            if (capture) begin
                ifid_pc_p1    <= pc_p0;
                ifid_pc4_p1   <= pc_plus4;
                ifid_instr_p1 <= imem_instr_i;
                vld_p1        <= 1'b1;
            end else if (squash) begin
                ifid_instr_p1 <= NOP_INSTR;
                vld_p1        <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (capture)   fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_inc) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

    assign imem_addr_o  = pc_p0;
    assign ifid_pc_o    = ifid_pc_p1;
    assign ifid_pc4_o   = ifid_pc4_p1;
    assign ifid_instr_o = ifid_instr_p1;
    assign ifid_valid_o = vld_p1;
    assign fault_o      = fault_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect, halt;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
    logic        ifid_valid, fault;
    logic [1:0]  state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: word i = 00A00093 + i.
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a < DEPTH * 4) return 32'h00A0_0093 + (a >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instr = memword(imem_addr);

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .halt_i       (halt),
        .imem_addr_o  (imem_addr),
        .imem_instr_i (imem_instr),
        .ifid_pc_o    (ifid_pc),
        .ifid_pc4_o   (ifid_pc4),
        .ifid_instr_o (ifid_instr),
        .ifid_valid_o (ifid_valid),
        .fault_o      (fault),
        .state_o      (state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o(fetch_count),
        .stall_count_o(stall_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the stage must hold after each edge.
    logic [1:0]  mstate;
    logic [31:0] mpc, mifpc, mifpc4, mifinstr, fcnt, scnt;
    logic        mvld, mfault;
    bit          model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            mstate = 2'b00; mpc = 32'h0; mifpc = 0; mifpc4 = 0;
            mifinstr = NOP; mvld = 0; mfault = 0; fcnt = 0; scnt = 0;
            model_live = 1;
        end else if (mstate == 2'b00) begin
            mstate = 2'b01;
        end else if (mstate == 2'b01) begin
            if (halt) begin
                mstate = 2'b10; mvld = 0; mifinstr = NOP;
            end else if ((mpc % 4 != 0) || (mpc >= DEPTH * 4)) begin
                mstate = 2'b10; mfault = 1; mvld = 0; mifinstr = NOP;
            end else if (redirect) begin
                mpc = redirect_pc; mvld = 0; mifinstr = NOP;
            end else if (stall) begin
                scnt++;
                if (flush) begin mvld = 0; mifinstr = NOP; end
            end else begin
                if (flush) begin
                    mvld = 0; mifinstr = NOP;
                end else begin
                    mifpc = mpc; mifpc4 = mpc + 4; mifinstr = memword(mpc);
                    mvld = 1; fcnt++;
                end
                mpc = mpc + 4;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("state", 32'(state), 32'(mstate));
            check("imem_addr", imem_addr, mpc);
            check("ifid_valid", 32'(ifid_valid), 32'(mvld));
            check("ifid_instr", ifid_instr, mifinstr);
            check("fault", 32'(fault), 32'(mfault));
            if (mvld) begin
                check("ifid_pc", ifid_pc, mifpc);
                check("ifid_pc4", ifid_pc4, mifpc4);
            end
`ifdef FETCH_PERF_CNT_EN
            check("fetch_count", fetch_count, fcnt);
            check("stall_count", stall_count, scnt);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; stall = 0; flush = 0; redirect = 0; halt = 0; redirect_pc = 0;
        cyc(); cyc();
        check("rst_state", 32'(state), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(ifid_valid), 32'h0);
        check("rst_instr", ifid_instr, 32'h13);
        check("rst_ifid_pc", ifid_pc, 32'h0);
        check("rst_ifid_pc4", ifid_pc4, 32'h0);
        check("rst_fault", 32'(fault), 32'h0);

        // Boot and first fetches.
        rst = 0;
        cyc();
        check("boot_state", 32'(state), 32'h1);
        check("boot_valid", 32'(ifid_valid), 32'h0);
        cyc();
        check("e1_instr", ifid_instr, 32'h00A00093);
        check("e1_valid", 32'(ifid_valid), 32'h1);
        cyc();
        check("e2_pc", ifid_pc, 32'h4);
        cyc();
        check("e3_pc", ifid_pc, 32'h8);
        check("e3_instr", ifid_instr, 32'h00A00095);
        check("e3_addr", imem_addr, 32'hC);

        // Three-cycle stall.
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_ifid_pc", ifid_pc, 32'h8);
            check("stall_addr", imem_addr, 32'hC);
        end
        stall = 0;
        cyc();
        check("post_stall_pc", ifid_pc, 32'hC);
        check("post_stall_addr", imem_addr, 32'h10);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt3", stall_count, 32'd3);
        check("fetch_cnt4", fetch_count, 32'd4);
`endif

        // Flush alone at PC=0x10.
        flush = 1;
        cyc();
        check("flush_valid", 32'(ifid_valid), 32'h0);
        check("flush_instr", ifid_instr, 32'h13);
        check("flush_addr", imem_addr, 32'h14);
        flush = 0;

        // Redirect together with stall.
        redirect = 1; redirect_pc = 32'h40; stall = 1;
        cyc();
        check("redir_addr", imem_addr, 32'h40);
        check("redir_valid", 32'(ifid_valid), 32'h0);
        redirect = 0; stall = 0;
        cyc();
        check("redir_tgt_pc", ifid_pc, 32'h40);
        check("redir_tgt_instr", ifid_instr, 32'h00A000A3);
        check("redir_tgt_valid", 32'(ifid_valid), 32'h1);

        // Stall with flush: squash while PC holds.
        stall = 1; flush = 1;
        cyc();
        check("stflush_valid", 32'(ifid_valid), 32'h0);
        check("stflush_addr", imem_addr, 32'h44);
        stall = 0; flush = 0;

        // Halt at PC=0x20, then reset while halted.
        redirect = 1; redirect_pc = 32'h20;
        cyc();
        redirect = 0; halt = 1;
        cyc();
        check("halt_state", 32'(state), 32'h2);
        check("halt_fault", 32'(fault), 32'h0);
        check("halt_addr", imem_addr, 32'h20);
        halt = 0; redirect = 1; redirect_pc = 32'h80;
        cyc(); cyc();
        check("halt_frozen_addr", imem_addr, 32'h20);
        rst = 1; stall = 1;
        cyc();
        check("rst2_state", 32'(state), 32'h0);
        check("rst2_addr", imem_addr, 32'h0);
        check("rst2_ifid_pc", ifid_pc, 32'h0);
        check("rst2_instr", ifid_instr, 32'h13);
        rst = 0; stall = 0; redirect = 0;

        // Misaligned redirect target.
        cyc();
        redirect = 1; redirect_pc = 32'h42;
        cyc();
        check("mis_addr", imem_addr, 32'h42);
        redirect = 0;
        cyc();
        check("mis_state", 32'(state), 32'h2);
        check("mis_fault", 32'(fault), 32'h1);
        check("mis_valid", 32'(ifid_valid), 32'h0);
        redirect = 1; redirect_pc = 32'h100;
        cyc(); cyc();
        check("mis_ignored", imem_addr, 32'h42);
        redirect = 0;

        // PC running off the end of memory.
        rst = 1;
        cyc();
        rst = 0;
        cyc();
        redirect = 1; redirect_pc = 32'hFFC;
        cyc();
        redirect = 0;
        cyc();
        check("last_pc", ifid_pc, 32'hFFC);
        check("last_instr", ifid_instr, 32'h00A00492);
        check("last_addr", imem_addr, 32'h1000);
        cyc();
        check("oor_state", 32'(state), 32'h2);
        check("oor_fault", 32'(fault), 32'h1);
        check("oor_valid", 32'(ifid_valid), 32'h0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns the program counter and drives the address of the combinational instruction memory. Captures the returned word into the IF/ID pipeline register for decode. Handles stalls, flushes, branch/jump redirects from EX, and a halt/fault state.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_DEPTH, 1024, instruction memory size in 32-bit words; legal fetch range is 0 .. IMEM_DEPTH*4-4
- NOP_INSTR, 32'h0000_0013, word placed in IF/ID when squashed (addi x0,x0,0)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hazard unit: hold PC and IF/ID
- flush_i  in  1  squash IF/ID contents
- redirect_i  in  1  taken branch/jump from EX
- redirect_pc_i  in  32  redirect target
- halt_i  in  1  request to stop fetching (ecall/ebreak retire)
- imem_addr_o  out  32  byte address to instruction memory (= PC register)
- imem_instr_i  in  32  combinational instruction-memory read data
- ifid_pc_o  out  32  PC of instruction in IF/ID
- ifid_pc4_o  out  32  ifid_pc_o + 4
- ifid_instr_o  out  32  instruction in IF/ID
- ifid_valid_o  out  1  IF/ID holds a real instruction
- fault_o  out  1  sticky: fetch address misaligned or out of range
- state_o  out  2  BOOT=00, RUN=01, HALT=10

## Operation
- Reset values: PC=RESET_PC, ifid_pc_o=0, ifid_pc4_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, fault_o=0, state_o=BOOT, counters=0.
- imem_addr_o is the PC register directly. imem_instr_i is valid in the same cycle.
- BOOT lasts exactly one cycle. PC and IF/ID are held and no capture occurs. The FSM then goes to RUN unconditionally.
- RUN edge priority, highest first:
  1. halt_i: state goes to HALT. IF/ID is squashed (valid=0, instr=NOP_INSTR). PC holds. fault_o is unchanged.
  2. fault: PC[1:0]!=0 or PC >= IMEM_DEPTH*4. state goes to HALT, fault_o goes to 1, IF/ID is squashed.
  3. redirect_i: PC loads redirect_pc_i and IF/ID is squashed. This applies even if stall_i=1.
  4. stall_i: PC holds. If flush_i=1, IF/ID is squashed; otherwise IF/ID holds.
  5. Otherwise: PC loads PC+4. If flush_i=1, IF/ID is squashed. If not, IF/ID loads {pc=PC, pc4=PC+4, instr=imem_instr_i, valid=1}.
- HALT:
  - PC is frozen and IF/ID stays squashed.
  - stall_i, flush_i, redirect_i and halt_i are ignored.
  - Only rst leaves HALT.
- A misaligned or out-of-range redirect target is accepted into PC. It faults on the following RUN edge and is never presented as a valid instruction.
- PC+4 wraps modulo 2^32. Any wrap is caught earlier by the range fault.
- rst asserted in any state, including mid-stall or mid-redirect, forces the reset values on that edge.

## Timing
- Fetch latency: the word at address X appears on ifid_instr_o with ifid_valid_o=1 one edge after imem_addr_o=X (if no stall, flush or redirect).
- First valid instruction: rst released before edge 0. Edge 0 is BOOT→RUN. Edge 1 captures RESET_PC into IF/ID.
- Redirect penalty: redirect_i at edge N gives PC=target after N and ifid_valid_o=0 after N. The target instruction is valid after N+1.
- A stall of k cycles keeps IF/ID and PC constant for k edges. Fetch resumes on the first edge with stall_i=0.
- All outputs are registered except imem_addr_o, which is the PC register itself (no combinational input-to-output paths).

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds outputs fetch_count_o (32) and stall_count_o (32).
  - fetch_count_o increments on every edge that loads IF/ID with valid=1.
  - stall_count_o increments on every RUN edge where stall_i=1 and no redirect or halt occurs.
  - Both counters wrap at 2^32, are cleared by rst, and freeze in HALT.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset with RESET_PC=0 and memory word i = 32'h00A00093+i. Run 5 cycles. Expect: state BOOT then RUN. IF/ID shows pc=0,4,8 with instr 00A00093, 00A00094, 00A00095 and valid=1 from edge 1.
- stall_i high for 3 cycles while IF/ID holds pc=8. Expect: ifid_pc_o=8 and imem_addr_o=12 constant for 3 edges; pc=12 captured on the next edge. With perf enabled, stall_count_o=3.
- redirect_i with redirect_pc_i=0x40 and stall_i=1 together. Expect: next cycle imem_addr_o=0x40 and ifid_valid_o=0. The following cycle ifid_pc_o=0x40 and valid=1.
- flush_i alone in RUN at PC=0x10. Expect: IF/ID valid=0 with instr 0x00000013, and PC advances to 0x14.
- redirect_pc_i=0x42, then separately PC reaching IMEM_DEPTH*4=0x1000. Expect: one edge later state_o=HALT and fault_o=1, never a valid IF/ID. Redirects are then ignored until rst.
- halt_i at PC=0x20, then rst mid-HALT. Expect: HALT with fault_o=0 and PC frozen at 0x20. rst restores PC=RESET_PC, state BOOT and all reset values.
